// File: rtl/mips_mem_pkg.sv
// Shared opcode encodings, LSU states and helpers for the MIPS load/store path.
`default_nettype none

package mips_mem_pkg;

  typedef enum logic [3:0] {
    OP_LB  = 4'd0,
    OP_LBU = 4'd1,
    OP_LH  = 4'd2,
    OP_LHU = 4'd3,
    OP_LW  = 4'd4,
    OP_LWL = 4'd5,
    OP_LWR = 4'd6,
    OP_SB  = 4'd8,
    OP_SH  = 4'd9,
    OP_SW  = 4'd10
  } mem_op_t;

  typedef enum logic {
    ST_IDLE      = 1'b0,
    ST_RMW_WRITE = 1'b1
  } lsu_state_t;

  localparam int          BYTE_W    = 8;
  localparam logic [31:0] WORD_MASK = 32'hFFFF_FFFF;

  function automatic logic op_is_load(input logic [3:0] op);
    return (op <= 4'd6);
  endfunction

  function automatic logic op_is_store(input logic [3:0] op);
    return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
  endfunction

  function automatic logic op_misaligned(input logic [3:0] op, input logic [1:0] off);
    logic bad;
    bad = 1'b0;
    case (op)
      OP_LH, OP_LHU, OP_SH: bad = off[0];
      OP_LW, OP_SW:         bad = (off != 2'b00);
      default:              bad = 1'b0;
    endcase
    return bad;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mips_load_align.sv
// Big-endian load shaping: sub-word extract with sign/zero extension and LWL/LWR merge.
`default_nettype none

module mips_load_align
  import mips_mem_pkg::*;
(
  input  logic [31:0] word,
  input  logic [3:0]  op,
  input  logic [1:0]  offset,
  input  logic [31:0] rt,
  output logic [31:0] result
);

  logic [4:0]        sh_left;
  logic [4:0]        sh_byte;
  logic [4:0]        sh_half;
  logic [BYTE_W-1:0] lane_byte;
  logic [15:0]       lane_half;

  // 8*k, 8*(3-k) and 8*(2-k); ~k equals 3-k for a two-bit offset
  assign sh_left   = {offset, 3'b000};
  assign sh_byte   = {~offset, 3'b000};
  assign sh_half   = {~offset[1], 4'b0000};
  assign lane_byte = BYTE_W'(word >> sh_byte);
  assign lane_half = 16'(word >> sh_half);

  always_comb begin
    result = '0;
    case (op)
      OP_LB:   result = {{24{lane_byte[7]}}, lane_byte};
      OP_LBU:  result = {24'h0, lane_byte};
      OP_LH:   result = {{16{lane_half[15]}}, lane_half};
      OP_LHU:  result = {16'h0, lane_half};
      OP_LW:   result = word;
      OP_LWL:  result = (word << sh_left) | (rt & ~(WORD_MASK << sh_left));
      OP_LWR:  result = (word >> sh_byte) | (rt & ~(WORD_MASK >> sh_byte));
      default: result = '0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/mips_lsu.sv
// MIPS load/store unit: one request at a time onto a word-addressed RAM without byte
// enables; sub-word stores are done as read-modify-write.
`default_nettype none

module mips_lsu
  import mips_mem_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic [3:0]  req_op,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [31:0] req_rt,
  output logic        req_ready,
  output logic        resp_valid,
  output logic [31:0] resp_data,
  output logic        resp_error,
  output logic [31:0] data_address,
  output logic        data_read,
  output logic        data_write,
  output logic [31:0] data_writedata,
  input  logic [31:0] data_readdata
);

  lsu_state_t  state;
  logic        busy;
  logic [29:0] rmw_addr;
  logic [31:0] rmw_word;

  logic        accept;
  logic        is_load;
  logic        is_sub_store;
  logic        access_ok;
  logic [1:0]  offset;
  logic [31:0] load_result;
  logic [4:0]  sub_shift;
  logic [31:0] sub_mask;
  logic [31:0] merged;

  assign offset       = req_addr[1:0];
  assign accept       = req_valid && !busy;
  assign is_load      = op_is_load(req_op);
  assign is_sub_store = (req_op == OP_SB) || (req_op == OP_SH);
  assign access_ok    = (is_load || op_is_store(req_op)) && !op_misaligned(req_op, offset);
  assign req_ready    = !busy;

  mips_load_align u_align (
    .word   (data_readdata),
    .op     (req_op),
    .offset (offset),
    .rt     (req_rt),
    .result (load_result)
  );

  // Replace only the addressed byte/halfword lane of the word read this cycle
  assign sub_shift = (req_op == OP_SB) ? {~offset, 3'b000} : {~offset[1], 4'b0000};
  assign sub_mask  = (req_op == OP_SB) ? 32'h0000_00FF : 32'h0000_FFFF;
  assign merged    = (data_readdata & ~(sub_mask << sub_shift))
                   | ((req_wdata & sub_mask) << sub_shift);

  assign data_read  = !reset && (state == ST_IDLE) && accept && access_ok
                    && (is_load || is_sub_store);
  assign data_write = !reset && ((state == ST_RMW_WRITE)
                    || ((state == ST_IDLE) && accept && access_ok && (req_op == OP_SW)));
  assign data_address   = (state == ST_RMW_WRITE) ? {rmw_addr, 2'b00} : {req_addr[31:2], 2'b00};
  assign data_writedata = (state == ST_RMW_WRITE) ? rmw_word : req_wdata;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      busy       <= 1'b0;
      resp_valid <= 1'b0;
      resp_data  <= '0;
      resp_error <= 1'b0;
      rmw_addr   <= '0;
      rmw_word   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          resp_valid <= 1'b0;
          resp_data  <= '0;
          resp_error <= 1'b0;
          if (accept) begin
            if (!access_ok) begin
              resp_valid <= 1'b1;
              resp_error <= 1'b1;
            end else if (is_sub_store) begin
              rmw_addr <= req_addr[31:2];
              rmw_word <= merged;
              state    <= ST_RMW_WRITE;
              busy     <= 1'b1;
            end else begin
              resp_valid <= 1'b1;
              resp_data  <= is_load ? load_result : 32'h0;
            end
          end
        end
        ST_RMW_WRITE: begin
          resp_valid <= 1'b1;
          resp_data  <= '0;
          resp_error <= 1'b0;
          state      <= ST_IDLE;
          busy       <= 1'b0;
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mips_lsu.sv
// Directed self-checking bench for mips_lsu with a small combinational-read RAM model.
`default_nettype none

module tb_mips_lsu;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic [3:0]  req_op;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [31:0] req_rt;
  logic        req_ready;
  logic        resp_valid;
  logic [31:0] resp_data;
  logic        resp_error;
  logic [31:0] data_address;
  logic        data_read;
  logic        data_write;
  logic [31:0] data_writedata;
  logic [31:0] data_readdata;

  int errors = 0;
  int checks = 0;

  logic [31:0] mem [0:3] = '{32'h1234_5678, 32'hEEEE_68AC, 32'h0, 32'h0};

  always #5 clk = ~clk;

  always @(posedge clk) if (data_write) mem[data_address[3:2]] <= data_writedata;
  assign data_readdata = mem[data_address[3:2]];

  mips_lsu dut (
    .clk            (clk),
    .reset          (reset),
    .req_valid      (req_valid),
    .req_op         (req_op),
    .req_addr       (req_addr),
    .req_wdata      (req_wdata),
    .req_rt         (req_rt),
    .req_ready      (req_ready),
    .resp_valid     (resp_valid),
    .resp_data      (resp_data),
    .resp_error     (resp_error),
    .data_address   (data_address),
    .data_read      (data_read),
    .data_write     (data_write),
    .data_writedata (data_writedata),
    .data_readdata  (data_readdata)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [3:0] op, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [31:0] rt);
    @(negedge clk);
    req_valid = 1'b1;
    req_op    = op;
    req_addr  = addr;
    req_wdata = wdata;
    req_rt    = rt;
  endtask

  task automatic load_chk(input string tag, input logic [3:0] op, input logic [31:0] addr,
                          input logic [31:0] rt, input logic [31:0] exp);
    drive(op, addr, 32'h0, rt);
    #1;
    chk({tag, "_rd"}, 32'(data_read), 32'd1);
    chk({tag, "_wr"}, 32'(data_write), 32'd0);
    chk({tag, "_addr"}, data_address, {addr[31:2], 2'b00});
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk({tag, "_vld"}, 32'(resp_valid), 32'd1);
    chk({tag, "_data"}, resp_data, exp);
    chk({tag, "_err"}, 32'(resp_error), 32'd0);
    @(posedge clk); #1;
    chk({tag, "_pulse"}, 32'(resp_valid), 32'd0);
  endtask

  task automatic err_chk(input string tag, input logic [3:0] op, input logic [31:0] addr);
    drive(op, addr, 32'hFFFF_FFFF, 32'h0);
    #1;
    chk({tag, "_rd"}, 32'(data_read), 32'd0);
    chk({tag, "_wr"}, 32'(data_write), 32'd0);
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk({tag, "_vld"}, 32'(resp_valid), 32'd1);
    chk({tag, "_err"}, 32'(resp_error), 32'd1);
    chk({tag, "_data"}, resp_data, 32'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset     = 1'b1;
    req_valid = 1'b1;
    req_op    = 4'd4;
    req_addr  = 32'h0;
    req_wdata = 32'h0;
    req_rt    = 32'h0;
    @(negedge clk);
    chk("rst_rd_forced", 32'(data_read), 32'd0);
    chk("rst_wr_forced", 32'(data_write), 32'd0);
    @(posedge clk); #1;
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_resp_data", resp_data, 32'h0);
    chk("rst_resp_error", 32'(resp_error), 32'd0);
    chk("rst_ready", 32'(req_ready), 32'd1);
    req_valid = 1'b0;
    reset     = 1'b0;
    @(posedge clk); #1;
    chk("idle_no_resp", 32'(resp_valid), 32'd0);

    load_chk("lb_4",   4'd0, 32'h4, 32'h0, 32'hFFFF_FFEE);
    load_chk("lbu_4",  4'd1, 32'h4, 32'h0, 32'h0000_00EE);
    load_chk("lh_6",   4'd2, 32'h6, 32'h0, 32'h0000_68AC);
    load_chk("lhu_4",  4'd3, 32'h4, 32'h0, 32'h0000_EEEE);
    load_chk("lw_0",   4'd4, 32'h0, 32'h0, 32'h1234_5678);
    load_chk("lwl_1",  4'd5, 32'h1, 32'hAABB_CCDD, 32'h3456_78DD);
    load_chk("lwr_1",  4'd6, 32'h1, 32'hAABB_CCDD, 32'hAABB_1234);
    load_chk("lwl_0",  4'd5, 32'h0, 32'hAABB_CCDD, 32'h1234_5678);
    load_chk("lwr_3",  4'd6, 32'h3, 32'hAABB_CCDD, 32'h1234_5678);

    // Back-to-back loads: second accepted while first response is visible
    drive(4'd4, 32'h0, 32'h0, 32'h0);
    @(posedge clk); #1;
    chk("b2b_first", resp_data, 32'h1234_5678);
    req_op   = 4'd0;
    req_addr = 32'h7;
    #1;
    chk("b2b_rd", 32'(data_read), 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("b2b_vld", 32'(resp_valid), 32'd1);
    chk("b2b_second", resp_data, 32'hFFFF_FFAC);

    // SB read-modify-write; a request presented during the write cycle is ignored
    drive(4'd8, 32'h2, 32'h0000_00AA, 32'h0);
    #1;
    chk("sb_n_rd", 32'(data_read), 32'd1);
    chk("sb_n_wr", 32'(data_write), 32'd0);
    @(posedge clk); #1;
    req_op   = 4'd4;
    req_addr = 32'h4;
    chk("sb_n1_wr", 32'(data_write), 32'd1);
    chk("sb_n1_rd", 32'(data_read), 32'd0);
    chk("sb_n1_wdata", data_writedata, 32'h1234_AA78);
    chk("sb_n1_addr", data_address, 32'h0);
    chk("sb_n1_ready", 32'(req_ready), 32'd0);
    chk("sb_n1_novld", 32'(resp_valid), 32'd0);
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("sb_n2_vld", 32'(resp_valid), 32'd1);
    chk("sb_n2_data", resp_data, 32'h0);
    chk("sb_n2_err", 32'(resp_error), 32'd0);
    @(posedge clk); #1;
    chk("busy_ignored", 32'(resp_valid), 32'd0);
    chk("sb_mem", mem[0], 32'h1234_AA78);
    load_chk("lw_after_sb", 4'd4, 32'h0, 32'h0, 32'h1234_AA78);

    // SW then immediate load of the same word
    drive(4'd10, 32'hC, 32'hCAFE_F00D, 32'h0);
    #1;
    chk("sw_wr", 32'(data_write), 32'd1);
    chk("sw_rd", 32'(data_read), 32'd0);
    @(posedge clk); #1;
    chk("sw_vld", 32'(resp_valid), 32'd1);
    req_op   = 4'd4;
    req_addr = 32'hC;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("lw_after_sw", resp_data, 32'hCAFE_F00D);

    err_chk("mis_lw_2",  4'd4,  32'h2);
    err_chk("mis_sh_5",  4'd9,  32'h5);
    err_chk("mis_lh_1",  4'd2,  32'h1);
    err_chk("unused_7",  4'd7,  32'h0);
    err_chk("unused_15", 4'd15, 32'h4);

    // Reset during the write cycle of SH 0x4 must abort the write
    drive(4'd9, 32'h4, 32'h0000_1111, 32'h0);
    @(posedge clk); #1;
    req_valid = 1'b0;
    reset     = 1'b1;
    #1;
    chk("rst_rmw_wr", 32'(data_write), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    chk("rst_rmw_vld", 32'(resp_valid), 32'd0);
    chk("rst_rmw_data", resp_data, 32'h0);
    chk("rst_rmw_err", 32'(resp_error), 32'd0);
    chk("rst_rmw_ready", 32'(req_ready), 32'd1);
    chk("rst_rmw_mem", mem[1], 32'hEEEE_68AC);
    load_chk("lw_4_after_rst", 4'd4, 32'h4, 32'h0, 32'hEEEE_68AC);

    // SH 0x6 completes normally
    drive(4'd9, 32'h6, 32'hFFFF_1357, 32'h0);
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("sh6_wdata", data_writedata, 32'hEEEE_1357);
    @(posedge clk); #1;
    chk("sh6_vld", 32'(resp_valid), 32'd1);
    load_chk("lw_after_sh", 4'd4, 32'h4, 32'h0, 32'hEEEE_1357);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mips_lsu.md
# mips_lsu

Load/store unit sitting between the MIPS core's memory stage and the data RAM port. It accepts one load or store request at a time and drives the RAM's word-addressed interface, which has combinational read, single-cycle write and no byte enables. It performs big-endian sub-word extraction, sign/zero extension and LWL/LWR merging. Sub-word stores are done as read-modify-write.

## Interface
Parameters:
- none. Opcode encoding and widths come from `mips_mem_pkg`.

Ports:
- Clock and reset: one clock; reset is synchronous and active-high.
- `clk`  in  1  — single clock.
- `reset`  in  1  — synchronous, active-high.
- `req_valid`  in  1  — request present this cycle.
- `req_op`  in  4  — `mem_op_t`: LB=0, LBU=1, LH=2, LHU=3, LW=4, LWL=5, LWR=6, SB=8, SH=9, SW=10.
- `req_addr`  in  32  — byte address.
- `req_wdata`  in  32  — store data; the low byte or halfword is used for SB/SH.
- `req_rt`  in  32  — current rt value, used only for the LWL/LWR merge.
- `req_ready`  out  1  — equals `!busy`.
- `resp_valid`  out  1  — one-cycle response pulse.
- `resp_data`  out  32  — load result; 0 for stores and errors.
- `resp_error`  out  1  — misaligned access.
- `data_address`  out  32  — word-aligned: `{req_addr[31:2],2'b00}`.
- `data_read`  out  1  — RAM read strobe.
- `data_write`  out  1  — RAM write strobe.
- `data_writedata`  out  32  — RAM write word.
- `data_readdata`  in  32  — RAM read word, valid in the same cycle as `data_read`.

## Operation
- **Accept rule:** a request is accepted when `req_valid && req_ready`.
  - Requests arriving while busy are ignored, not queued.
- **States:** IDLE and RMW_WRITE.
- **Byte lanes (big-endian):** byte offset k = `addr[1:0]`; byte k is at bits `[31-8k -: 8]`.
- **Alignment:**
  - LH, LHU and SH require `addr[0]==0`.
  - LW and SW require `addr[1:0]==0`.
  - LB, LBU, SB, LWL and LWR have no alignment requirement.
  - A misaligned request causes no RAM strobe. In the next cycle `resp_valid=1`, `resp_error=1` and `resp_data=0`.
- **Loads (IDLE):** drive `data_read=1` and the aligned address combinationally. The shaped result is registered and presented in the next cycle.
  - LB/LH sign-extend; LBU/LHU zero-extend.
  - LWL: `(mem << 8k) | (rt & ((1<<8k)-1))`.
  - LWR: `(mem >> 8(3-k)) | (rt & ~(32'hFFFFFFFF >> 8(3-k)))`.
- **SW (IDLE):** drive `data_write=1` with `data_writedata=req_wdata`. Response in the next cycle.
- **SB/SH:**
  - In IDLE: drive `data_read=1` and capture `data_readdata` into a merge register. Latch the address, lane and store data. Go to RMW_WRITE.
  - In RMW_WRITE: drive `data_write=1` with the merged word (only the target byte or halfword is replaced). Return to IDLE.
  - The response follows in the next cycle.
- **Busy:** `busy=1` exactly while in RMW_WRITE.
- **Unused opcodes (7, 11–15):** treated as a no-op. No RAM access; `resp_valid=1` next cycle with `resp_error=1`.

## Timing
- **Reset:** while `reset=1`, the next state is IDLE and `resp_valid`, `resp_data`, `resp_error` and `busy` are registered to 0.
  - `data_read` and `data_write` are forced to 0 combinationally whenever `reset=1`.
  - Consequence: reset asserted during the RMW_WRITE cycle aborts the write and leaves memory unchanged.
- **Latency:**
  - Loads, SW and errors: `resp_valid` in cycle N+1 after acceptance in cycle N.
  - SB/SH: read in N, write in N+1, `resp_valid` in N+2.
- **Back-to-back:** a new request may be accepted in the same cycle that `resp_valid` is high for the previous one. A full load rate of one per cycle is allowed.
- **Strobes:** never both asserted. Both are 0 in IDLE when no request is accepted. `data_address` is don't-care when no strobe is asserted.
- **Write/read forwarding:** none. A load accepted in the cycle after a write returns the newly written data, because the RAM updates on the write edge.

## Structure
- **Package `mips_mem_pkg`:**
  - `mem_op_t` enum and its encodings.
  - `lsu_state_t` (IDLE, RMW_WRITE).
  - Helper constants: `WORD_MASK`, `BYTE_W=8`.
- **Sub-module `mips_load_align`:** purely combinational. Inputs are word, op, offset and rt; output is the shaped 32-bit result. It is instantiated once in `mips_lsu`.
- The store-merge logic stays inline in `mips_lsu`.

## Test plan
RAM preloaded with word 0x0 = 0x12345678 and word 0x4 = 0xEEEE68AC.
- **Loads:**
  - LB 0x4 → 0xFFFFFFEE.
  - LBU 0x4 → 0x000000EE.
  - LH 0x6 → 0x000068AC.
  - LW 0x0 → 0x12345678.
  - Each with `resp_valid` exactly one cycle after accept.
- **Read-modify-write:** SB 0x2 with wdata 0x000000AA.
  - Cycle N: `data_read=1`. Cycle N+1: `data_write=1`, data 0x1234AA78, `req_ready=0`.
  - Cycle N+2: `resp_valid=1`.
  - A following LW 0x0 returns 0x1234AA78.
- **Merges:**
  - LWL 0x1 with rt=0xAABBCCDD → 0x345678DD.
  - LWR 0x1 with rt=0xAABBCCDD → 0xAABB1234.
- **Misaligned:** LW 0x2 and SH 0x5 → no `data_read`/`data_write`; next cycle `resp_error=1`, `resp_data=0`.
- **Busy/reset:**
  - A request presented during RMW_WRITE is ignored: no extra response.
  - `reset` asserted in the RMW_WRITE cycle of SH 0x4 → `data_write` stays 0; word 0x4 remains 0xEEEE68AC; all outputs are 0 after the reset cycle.
